// File: rtl/axi4_ddr_slave_model.sv
// axi4_ddr_slave_model
// AXI4 full slave backed by an on-chip byte-enabled RAM. It stands in for the
// DDR controller so the AXI write and read paths can be exercised end to end.
// The write (AW/W/B) and read (AR/R) channels are independent state machines
// that share only the RAM, with one outstanding burst per direction.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN        clock, synchronous active-low reset
//   S_AXI_AW*                        write address channel
//   S_AXI_W*                         write data channel (byte strobes)
//   S_AXI_B*                         write response channel
//   S_AXI_AR*                        read address channel
//   S_AXI_R*                         read data channel
//
// Addressing: word index = ADDR[ADDR_LSB +: P_MEM_DEPTH_LOG2]; higher bits
// alias. Bursts always step one word per beat and wrap modulo the RAM depth.
// Non-INCR bursts, a SIZE other than the full bus width and (for writes) a
// misplaced WLAST are still executed as INCR but answered with SLVERR.
module axi4_ddr_slave_model #(
    parameter int C_S_AXI_ID_WIDTH   = 2,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int P_MEM_DEPTH_LOG2   = 12
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int ADDR_LSB  = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam int MEM_DEPTH = 1 << P_MEM_DEPTH_LOG2;

    localparam logic [2:0] SIZE_FULL   = 3'(ADDR_LSB);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [P_MEM_DEPTH_LOG2-1:0] WORD_ONE = P_MEM_DEPTH_LOG2'(1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    // A burst is flagged when it is not INCR or does not use the full bus width.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst != BURST_INCR) || (size != SIZE_FULL);
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // write channel state
    w_state_t                      w_state_r, w_state_next_s;
    logic                          aw_hs_s, w_hs_s, b_hs_s, wlast_bad_s;
    logic                          awready_r, wready_r, bvalid_r, w_err_r;
    logic [C_S_AXI_ID_WIDTH-1:0]   w_id_r, bid_r;
    logic [1:0]                    bresp_r;
    logic [P_MEM_DEPTH_LOG2-1:0]   w_word_r;
    logic [7:0]                    w_len_r, w_cnt_r;

    // read channel state
    r_state_t                      r_state_r, r_state_next_s;
    logic                          ar_hs_s, r_hs_s, rd_en_s;
    logic [P_MEM_DEPTH_LOG2-1:0]   rd_addr_s;
    logic                          arready_r, rvalid_r, rlast_r;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_r;
    logic [1:0]                    rresp_r;
    logic [P_MEM_DEPTH_LOG2-1:0]   r_word_r;
    logic [7:0]                    r_len_r, r_cnt_r;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

    // address bits above the RAM window are deliberately ignored (aliasing)
    logic unused_addr_s;
    assign unused_addr_s = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    // Write FSM next state and handshake decode.
    always_comb begin
        w_state_next_s = w_state_r;
        aw_hs_s        = 1'b0;
        w_hs_s         = 1'b0;
        b_hs_s         = 1'b0;
        wlast_bad_s    = S_AXI_WLAST != (w_cnt_r == w_len_r);
        case (w_state_r)
            W_IDLE: begin
                aw_hs_s = S_AXI_AWVALID && awready_r;
                if (aw_hs_s) w_state_next_s = W_DATA;
                else         w_state_next_s = W_IDLE;
            end
            W_DATA: begin
                w_hs_s = S_AXI_WVALID && wready_r;
                // beat count follows AWLEN; WLAST only affects the response
                if (w_hs_s && (w_cnt_r == w_len_r)) w_state_next_s = W_RESP;
                else                                w_state_next_s = W_DATA;
            end
            W_RESP: begin
                b_hs_s = S_AXI_BREADY && bvalid_r;
                if (b_hs_s) w_state_next_s = W_IDLE;
                else        w_state_next_s = W_RESP;
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) w_state_r <= W_IDLE;
        else                w_state_r <= w_state_next_s;
    end

    // Write channel registered outputs and burst bookkeeping.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= RESP_OKAY;
            w_id_r    <= '0;
            w_word_r  <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_err_r   <= 1'b0;
        end else begin
            awready_r <= (w_state_next_s == W_IDLE);
            wready_r  <= (w_state_next_s == W_DATA);
            bvalid_r  <= (w_state_next_s == W_RESP);
            if (aw_hs_s) begin
                w_id_r   <= S_AXI_AWID;
                w_word_r <= S_AXI_AWADDR[ADDR_LSB +: P_MEM_DEPTH_LOG2];
                w_len_r  <= S_AXI_AWLEN;
                w_cnt_r  <= 8'd0;
                w_err_r  <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
            end else if (w_hs_s) begin
                w_word_r <= w_word_r + WORD_ONE;
                w_cnt_r  <= w_cnt_r + 8'd1;
                w_err_r  <= w_err_r || wlast_bad_s;
                if (w_cnt_r == w_len_r) begin
                    bid_r   <= w_id_r;
                    bresp_r <= (w_err_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Byte-lane RAM write; a beat on a reset cycle is discarded.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN && w_hs_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (S_AXI_WSTRB[i]) mem[w_word_r][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    // Read FSM next state, handshake decode and RAM read address.
    always_comb begin
        r_state_next_s = r_state_r;
        ar_hs_s        = 1'b0;
        r_hs_s         = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                ar_hs_s = S_AXI_ARVALID && arready_r;
                if (ar_hs_s) r_state_next_s = R_FETCH;
                else         r_state_next_s = R_IDLE;
            end
            R_FETCH: r_state_next_s = R_DATA;
            R_DATA: begin
                r_hs_s = S_AXI_RREADY && rvalid_r;
                if (r_hs_s && rlast_r) r_state_next_s = R_IDLE;
                else                   r_state_next_s = R_DATA;
            end
            default: r_state_next_s = R_IDLE;
        endcase
        // RDATA only reloads on fetch or accepted beat, so it holds while stalled
        rd_en_s   = (r_state_r == R_FETCH) || r_hs_s;
        rd_addr_s = r_hs_s ? (r_word_r + WORD_ONE) : r_word_r;
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_state_r <= R_IDLE;
        else                r_state_r <= r_state_next_s;
    end

    // Read channel registered outputs and burst bookkeeping.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rid_r     <= '0;
            r_word_r  <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
        end else begin
            arready_r <= (r_state_next_s == R_IDLE);
            rvalid_r  <= (r_state_next_s == R_DATA);
            if (ar_hs_s) begin
                rid_r    <= S_AXI_ARID;
                rresp_r  <= burst_err(S_AXI_ARBURST, S_AXI_ARSIZE) ? RESP_SLVERR : RESP_OKAY;
                r_word_r <= S_AXI_ARADDR[ADDR_LSB +: P_MEM_DEPTH_LOG2];
                r_len_r  <= S_AXI_ARLEN;
                r_cnt_r  <= 8'd0;
                rlast_r  <= 1'b0;
            end else if (r_state_r == R_FETCH) begin
                rlast_r  <= (r_len_r == 8'd0);
            end else if (r_hs_s) begin
                r_word_r <= r_word_r + WORD_ONE;
                r_cnt_r  <= r_cnt_r + 8'd1;
                // the accepted last beat clears RLAST; otherwise flag the next one
                rlast_r  <= !rlast_r && ((r_cnt_r + 8'd1) == r_len_r);
            end
        end
    end

    // Registered RAM read port; read-first against a same-cycle write.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) rdata_r <= '0;
        else if (rd_en_s)   rdata_r <= mem[rd_addr_s];
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BID     = bid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RID     = rid_r;
    assign S_AXI_RDATA   = rdata_r;

endmodule

// File: tb/tb_axi4_ddr_slave_model.sv
// Self-checking bench for axi4_ddr_slave_model (default parameters).
// A word-array memory model plus expected-response queues predict every R
// beat and B response; a negedge monitor compares the DUT against them.
module tb_axi4_ddr_slave_model;

    localparam int DEPTH = 4096;

    logic        clk;
    logic        S_AXI_ARESETN;
    logic [1:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN, S_AXI_WSTRB;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
    logic [63:0] S_AXI_WDATA, S_AXI_RDATA;

    axi4_ddr_slave_model dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] data; logic last; logic [1:0] resp; logic [1:0] id; } r_beat_t;
    typedef struct packed { logic [1:0] resp; logic [1:0] id; } b_rsp_t;

    logic [63:0] ref_mem [0:DEPTH-1];
    r_beat_t     r_exp[$];
    b_rsp_t      b_exp[$];
    logic [63:0] rd_got  [0:255];
    logic        rd_last [0:255];
    logic [1:0]  rd_resp [0:255];
    logic [1:0]  last_bresp, last_bid;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // WLAST pattern driven on beat k: on the early beat if requested, else on the last.
    function automatic logic wl(input int k, input int len, input int early_at);
        return (early_at >= 0) ? (k == early_at) : (k == len);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        S_AXI_ARESETN = 1'b0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0; S_AXI_WLAST = 1'b0;
        r_exp.delete();
        b_exp.delete();
        tick();
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_wready",  S_AXI_WREADY,  1'b0);
        check("rst_bvalid",  S_AXI_BVALID,  1'b0);
        check("rst_bresp",   S_AXI_BRESP,   2'b00);
        check("rst_bid",     S_AXI_BID,     2'b00);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_rvalid",  S_AXI_RVALID,  1'b0);
        check("rst_rlast",   S_AXI_RLAST,   1'b0);
        check("rst_rresp",   S_AXI_RRESP,   2'b00);
        check("rst_rid",     S_AXI_RID,     2'b00);
        check("rst_rdata",   S_AXI_RDATA,   64'd0);
        S_AXI_ARESETN = 1'b1;
        tick();
        check("post_rst_awready", S_AXI_AWREADY, 1'b1);
        check("post_rst_arready", S_AXI_ARREADY, 1'b1);
    endtask

    task automatic write_burst(input logic [1:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input logic [2:0] size,
                               input logic [7:0] strb, input logic rand_strb,
                               input logic [63:0] base, input logic rand_data,
                               input int early_at, input logic throttle, input int abort_after);
        int start, i, t;
        logic bad, hs;
        logic [63:0] d;
        logic [7:0] s;
        b_rsp_t b;
        start = int'((addr >> 3) & 32'hFFF);
        bad = 1'b0;
        for (int k = 0; k <= len; k++) if (wl(k, len, early_at) != (k == len)) bad = 1'b1;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
        S_AXI_AWBURST = burst; S_AXI_AWSIZE = size; S_AXI_AWVALID = 1'b1;
        t = 0;
        do begin
            hs = S_AXI_AWVALID && S_AXI_AWREADY;
            tick(); t++;
        end while (!hs && t < 50);
        S_AXI_AWVALID = 1'b0;
        check("aw_handshake", hs, 1'b1);
        if (!hs) return;
        i = 0; t = 0;
        while (i <= len && t < 5000) begin
            S_AXI_WVALID = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rand_data ? {$urandom, $urandom} : base + 64'(i);
            s = rand_strb ? 8'($urandom) : strb;
            S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WLAST = wl(i, len, early_at);
            hs = S_AXI_WVALID && S_AXI_WREADY;
            tick(); t++;
            if (hs) begin
                for (int k = 0; k < 8; k++)
                    if (s[k]) ref_mem[(start + i) % DEPTH][8*k +: 8] = d[8*k +: 8];
                i++;
                if (i == abort_after) begin
                    S_AXI_WVALID = 1'b0;
                    do_reset();
                    return;
                end
            end
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check("w_all_beats", (i > len), 1'b1);
        b.id = id;
        b.resp = (burst != 2'b01 || size != 3'd3 || bad) ? 2'b10 : 2'b00;
        b_exp.push_back(b);
        t = 0;
        do begin
            S_AXI_BREADY = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = S_AXI_BVALID && S_AXI_BREADY;
            if (hs) begin last_bresp = S_AXI_BRESP; last_bid = S_AXI_BID; end
            tick(); t++;
        end while (!hs && t < 200);
        S_AXI_BREADY = 1'b0;
        check("b_handshake", hs, 1'b1);
    endtask

    task automatic read_burst(input logic [1:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [2:0] size,
                              input logic throttle, input logic check_lat, input int abort_after);
        int start, n, t, lat;
        logic hs;
        r_beat_t e;
        start = int'((addr >> 3) & 32'hFFF);
        for (int k = 0; k <= len; k++) begin
            e.data = ref_mem[(start + k) % DEPTH];
            e.last = (k == len);
            e.resp = (burst != 2'b01 || size != 3'd3) ? 2'b10 : 2'b00;
            e.id   = id;
            r_exp.push_back(e);
        end
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
        S_AXI_ARBURST = burst; S_AXI_ARSIZE = size; S_AXI_ARVALID = 1'b1;
        t = 0;
        do begin
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            tick(); t++;
        end while (!hs && t < 50);
        S_AXI_ARVALID = 1'b0;
        check("ar_handshake", hs, 1'b1);
        if (!hs) return;
        lat = 1;
        while (!S_AXI_RVALID && lat < 10) begin tick(); lat++; end
        if (check_lat) check("r_first_latency", lat, 2);
        n = 0; t = 0;
        while (n <= len && t < 5000) begin
            S_AXI_RREADY = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = S_AXI_RVALID && S_AXI_RREADY;
            if (hs) begin rd_got[n] = S_AXI_RDATA; rd_last[n] = S_AXI_RLAST; rd_resp[n] = S_AXI_RRESP; end
            tick(); t++;
            if (hs) begin
                n++;
                if (n == abort_after) begin
                    S_AXI_RREADY = 1'b0;
                    do_reset();
                    return;
                end
            end
        end
        S_AXI_RREADY = 1'b0;
        check("r_all_beats", (n > len), 1'b1);
        check("r_queue_drained", r_exp.size(), 0);
    endtask

    // Every cycle out of reset: each visible R beat / B response must match the model.
    always @(negedge clk) begin
        if (S_AXI_ARESETN === 1'b1) begin
            if (S_AXI_RVALID) begin
                if (r_exp.size() == 0) begin
                    check("r_unexpected_beat", S_AXI_RVALID, 1'b0);
                end else begin
                    check("rdata", S_AXI_RDATA, r_exp[0].data);
                    check("rlast", S_AXI_RLAST, r_exp[0].last);
                    check("rresp", S_AXI_RRESP, r_exp[0].resp);
                    check("rid",   S_AXI_RID,   r_exp[0].id);
                    if (S_AXI_RREADY) void'(r_exp.pop_front());
                end
            end
            if (S_AXI_BVALID) begin
                if (b_exp.size() == 0) begin
                    check("b_unexpected", S_AXI_BVALID, 1'b0);
                end else begin
                    check("bresp", S_AXI_BRESP, b_exp[0].resp);
                    check("bid",   S_AXI_BID,   b_exp[0].id);
                    if (S_AXI_BREADY) void'(b_exp.pop_front());
                end
            end
        end
    end

    initial begin
        int nlast;
        logic [31:0] a;
        int len;
        S_AXI_AWID = 2'd0; S_AXI_AWADDR = 32'd0; S_AXI_AWLEN = 8'd0; S_AXI_AWSIZE = 3'd3;
        S_AXI_AWBURST = 2'b01; S_AXI_WDATA = 64'd0; S_AXI_WSTRB = 8'd0;
        S_AXI_ARID = 2'd0; S_AXI_ARADDR = 32'd0; S_AXI_ARLEN = 8'd0; S_AXI_ARSIZE = 3'd3;
        S_AXI_ARBURST = 2'b01;
        do_reset();

        // 16-beat incrementing write then readback
        write_burst(2'd2, 32'h100, 15, 2'b01, 3'd3, 8'hFF, 1'b0, 64'd0, 1'b0, -1, 1'b0, -1);
        check("t1_bresp_lit", last_bresp, 2'b00);
        check("t1_bid_lit", last_bid, 2'd2);
        check("t1_model_w32", ref_mem[32], 64'd0);
        check("t1_model_w47", ref_mem[47], 64'd15);
        read_burst(2'd1, 32'h100, 15, 2'b01, 3'd3, 1'b0, 1'b1, -1);
        check("t1_rdata0_lit", rd_got[0], 64'd0);
        check("t1_rdata15_lit", rd_got[15], 64'd15);
        check("t1_rdata7_lit", rd_got[7], 64'd7);
        nlast = 0;
        for (int k = 0; k < 16; k++) nlast += int'(rd_last[k]);
        check("t1_rlast_count", nlast, 1);
        check("t1_rlast_beat15", rd_last[15], 1'b1);

        // partial strobe over all-ones
        write_burst(2'd0, 32'h200, 0, 2'b01, 3'd3, 8'hFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 1'b0, -1);
        write_burst(2'd0, 32'h200, 0, 2'b01, 3'd3, 8'h0F, 1'b0, 64'hAAAA_AAAA_1234_5678, 1'b0, -1, 1'b0, -1);
        read_burst(2'd3, 32'h200, 0, 2'b01, 3'd3, 1'b0, 1'b1, -1);
        check("t2_strobe_lit", rd_got[0], 64'hFFFF_FFFF_1234_5678);
        check("t2_len0_rlast", rd_last[0], 1'b1);

        // 64-beat throttled write and read
        write_burst(2'd1, 32'h1000, 63, 2'b01, 3'd3, 8'hFF, 1'b0, 64'd0, 1'b1, -1, 1'b1, -1);
        read_burst(2'd2, 32'h1000, 63, 2'b01, 3'd3, 1'b1, 1'b0, -1);

        // wrap at the last word, plus aliasing above the RAM size
        write_burst(2'd0, 32'h7FF8, 1, 2'b01, 3'd3, 8'hFF, 1'b0, 64'hC0DE_0000, 1'b0, -1, 1'b0, -1);
        check("t4_model_wrap", ref_mem[0], 64'hC0DE_0001);
        read_burst(2'd0, 32'h0, 0, 2'b01, 3'd3, 1'b0, 1'b0, -1);
        check("t4_wrap_lit", rd_got[0], 64'hC0DE_0001);
        read_burst(2'd0, 32'h8000, 0, 2'b01, 3'd3, 1'b0, 1'b0, -1);
        check("t4_alias_lit", rd_got[0], 64'hC0DE_0001);
        read_burst(2'd1, 32'h7FF8, 1, 2'b01, 3'd3, 1'b0, 1'b0, -1);
        check("t4_wrap_read_lit", rd_got[1], 64'hC0DE_0001);

        // error responses
        read_burst(2'd1, 32'h100, 3, 2'b00, 3'd3, 1'b0, 1'b0, -1);
        for (int k = 0; k < 4; k++) check("t5_fixed_rresp_lit", rd_resp[k], 2'b10);
        check("t5_fixed_data_lit", rd_got[3], 64'd3);
        read_burst(2'd1, 32'h100, 1, 2'b01, 3'd2, 1'b0, 1'b0, -1);
        check("t5_size_rresp_lit", rd_resp[0], 2'b10);
        write_burst(2'd3, 32'h300, 3, 2'b01, 3'd3, 8'hFF, 1'b0, 64'h50, 1'b0, 1, 1'b0, -1);
        check("t5_wlast_early_lit", last_bresp, 2'b10);
        write_burst(2'd3, 32'h300, 3, 2'b10, 3'd3, 8'hFF, 1'b0, 64'h60, 1'b0, -1, 1'b0, -1);
        check("t5_wrap_burst_lit", last_bresp, 2'b10);
        read_burst(2'd2, 32'h300, 3, 2'b01, 3'd3, 1'b0, 1'b0, -1);
        check("t5_wrap_burst_data_lit", rd_got[2], 64'h62);

        // reset mid read burst and mid write burst, then normal traffic
        read_burst(2'd1, 32'h1000, 63, 2'b01, 3'd3, 1'b0, 1'b0, 5);
        read_burst(2'd1, 32'h100, 15, 2'b01, 3'd3, 1'b0, 1'b1, -1);
        write_burst(2'd2, 32'h2000, 15, 2'b01, 3'd3, 8'hFF, 1'b0, 64'h900, 1'b0, -1, 1'b0, 4);
        write_burst(2'd1, 32'h2800, 7, 2'b01, 3'd3, 8'hFF, 1'b0, 64'hA00, 1'b0, -1, 1'b0, -1);
        check("t6_post_rst_bresp_lit", last_bresp, 2'b00);
        read_burst(2'd0, 32'h2000, 3, 2'b01, 3'd3, 1'b0, 1'b0, -1);
        check("t6_aborted_beat_lit", rd_got[3], 64'h903);
        read_burst(2'd0, 32'h2800, 7, 2'b01, 3'd3, 1'b0, 1'b0, -1);

        // randomized bursts: full write, random-strobe overwrite, throttled readback
        for (int it = 0; it < 8; it++) begin
            a = $urandom;
            len = $urandom_range(0, 31);
            write_burst(2'($urandom), a, len, 2'b01, 3'd3, 8'hFF, 1'b0, 64'd0, 1'b1, -1, 1'b1, -1);
            write_burst(2'($urandom), a, len, 2'b01, 3'd3, 8'h00, 1'b1, 64'd0, 1'b1, -1, 1'b1, -1);
            read_burst(2'($urandom), a, len, 2'b01, 3'd3, 1'b1, 1'b0, -1);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_ddr_slave_model.md
# axi4_ddr_slave_model

Synthesizable AXI4 full slave that answers the write (AW/W/B) and read (AR/R) channels issued by the AXI4 bus master, backed by an on-chip byte-enabled RAM. It stands in for the DDR controller in block-level simulation and in DDR-less FPGA builds, so the AXIS-to-AXI write path and the AXI-to-AXIS read path can be exercised end to end. Write and read channels are fully independent state machines sharing only the RAM.

## Interface
Parameters:
- C_S_AXI_ID_WIDTH, 2: AXI ID width.
- C_S_AXI_ADDR_WIDTH, 32: byte address width.
- C_S_AXI_DATA_WIDTH, 64: data width. Must be 32, 64 or 128.
- P_MEM_DEPTH_LOG2, 12: log2 of the RAM depth in data words. The default is 4096 x 64 b, which is 32 KiB.

Ports:
- S_AXI_ACLK, in, 1: the single clock.
- S_AXI_ARESETN, in, 1: reset, synchronous, active-low.
- S_AXI_AWID / AWADDR / AWLEN / AWSIZE / AWBURST, in, ID / ADDR / 8 / 3 / 2: write address.
- S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1.
- S_AXI_WDATA / WSTRB / WLAST / WVALID, in, DATA / DATA/8 / 1 / 1; S_AXI_WREADY, out, 1.
- S_AXI_BID / BRESP / BVALID, out, ID / 2 / 1; S_AXI_BREADY, in, 1.
- S_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST, in, ID / ADDR / 8 / 3 / 2: read address.
- S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1.
- S_AXI_RID / RDATA / RRESP / RLAST / RVALID, out, ID / DATA / 2 / 1 / 1; S_AXI_RREADY, in, 1.

## Operation
Address mapping:
- ADDR_LSB = log2(DATA/8).
- The word index is ADDR[ADDR_LSB +: P_MEM_DEPTH_LOG2]. Higher bits are ignored, so the address space aliases modulo the RAM size.
- Burst addresses increment by one word per beat and wrap modulo the depth. There is no 4 KiB boundary check.

Response codes:
- A burst gets an error response, SLVERR (2'b10), if any of the following holds:
  - BURST != INCR (2'b01); the burst is still executed as INCR.
  - SIZE != ADDR_LSB.
  - For writes only: WLAST disagrees with the beat count (WLAST seen early, or missing on beat LEN).
- All other bursts get OKAY (2'b00).

Write FSM, states W_IDLE, W_DATA, W_RESP:
- W_IDLE: AWREADY=1. On AWVALID, latch ID, start word, LEN, error flag and clear the beat counter, then go to W_DATA.
- W_DATA: WREADY=1. Each W handshake writes the lanes enabled by WSTRB at the current word, then increments the word and the counter. The handshake where counter==LEN goes to W_RESP; beat count is governed by LEN, not WLAST.
- W_RESP: BVALID=1, with BID and BRESP held. On BREADY, go to W_IDLE.

Read FSM, states R_IDLE, R_FETCH, R_DATA:
- R_IDLE: ARREADY=1. On ARVALID, latch ID, start word, LEN and error flag, then go to R_FETCH.
- R_FETCH: one cycle to read the RAM at the start word.
- R_DATA: RVALID=1, RLAST=(counter==LEN). The RAM read address is next_word when an R handshake occurs, else the current word, so RDATA is registered and beats can stream back to back. On a handshake with RLAST, go to R_IDLE.
- RRESP is held at the burst's error status on every beat.

Collisions and ordering:
- A same-word read and write in the same cycle is read-first: RDATA returns the old data.
- Writes and reads are unordered relative to each other.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0. Both FSMs go to IDLE. RAM contents are not cleared.
- READY signals rise on the first cycle after reset is released.
- Reset mid-burst aborts the burst with no B or R response, and the FSMs are in IDLE on the next cycle.
- AWREADY and ARREADY are registered. Each drops the cycle after its handshake and rises again the cycle after the matching B handshake or final R handshake. One outstanding transaction per direction.
- Write throughput: 1 beat per cycle while WVALID=1. BVALID asserts the cycle after the last W handshake.
- Read latency: AR handshake in cycle t gives R_FETCH in t+1 and first RVALID in t+2.
- Read throughput: 1 beat per cycle while RREADY=1. When RREADY=0, RDATA, RLAST and RVALID are held stable.
- LEN=0 is a single beat: RLAST=1 on the first R beat, and the W burst completes on the first beat.

## Test plan
- Write AWADDR=0x100, AWLEN=15, full WSTRB, data = beat index. Required: BRESP=OKAY, BID echoed. Then read the same range with ARLEN=15. Required: 16 beats with data 0..15, RLAST only on beat 15, first RVALID 2 cycles after the AR handshake.
- Write one beat with WSTRB=0x0F over a prior 0xFFFF_FFFF_FFFF_FFFF. Required: readback 0xFFFF_FFFF_xxxx_xxxx, with the low word updated and the high word preserved.
- Random RREADY and WVALID throttling (50 %) on a 64-beat burst. Required: no lost or duplicated beats, RDATA stable while RREADY=0, BVALID held until BREADY.
- Write burst starting at the last word (0x7FF8 for the default) with AWLEN=1. Required: the second beat lands at word 0. Also ARBURST=FIXED gives RRESP=SLVERR on every beat, and WLAST asserted early gives BRESP=SLVERR.
- Assert S_AXI_ARESETN low mid read burst and mid write burst. Required: all outputs at reset values the next cycle, and a new burst after reset completes normally.
